// File: rtl/light_pkg.sv
// Phase encoding and sequencing helpers shared by the traffic-light phase timer.
package light_pkg;

   typedef enum logic [2:0] {RED, RED_AMBER, GREEN, AMBER, ILLEGAL} phase_t;
   typedef enum logic {TIMING, WAIT_CHANGE} tstate_t;

   localparam logic [2:0] LIGHT_RED       = 3'b100;
   localparam logic [2:0] LIGHT_RED_AMBER = 3'b110;
   localparam logic [2:0] LIGHT_GREEN     = 3'b001;
   localparam logic [2:0] LIGHT_AMBER     = 3'b010;

   function automatic phase_t decode_light(input logic [2:0] light);
      phase_t p;
      case (light)
         LIGHT_RED:       p = RED;
         LIGHT_RED_AMBER: p = RED_AMBER;
         LIGHT_GREEN:     p = GREEN;
         LIGHT_AMBER:     p = AMBER;
         default:         p = ILLEGAL;
      endcase
      return p;
   endfunction

   function automatic phase_t next_phase(input phase_t p);
      phase_t n;
      case (p)
         RED:       n = RED_AMBER;
         RED_AMBER: n = GREEN;
         GREEN:     n = AMBER;
         AMBER:     n = RED;
         default:   n = ILLEGAL;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter used for phase dwell and stall timing.
// Latency: registered, new value visible one clk after load/clr/dec.
// Backpressure: none; callers must not decrement at zero.
module phase_counter #(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] q,
   output logic             is_one
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (clr) begin
         q <= '0;
      end else if (dec) begin
         q <= q - 1'b1;
      end
   end

   assign is_one = (q == CNT_W'(1));

endmodule

// File: rtl/light_phase_timer.sv
// Phase dwell timer, pedestrian arbiter and sequence checker for the traffic-light sequencer.
// Latency: step/ped_ack/fault registered, one clk after the deciding edge.
// Backpressure: none; step is a bare pulse and the sequencer must react within the stall window.
module light_phase_timer
   import light_pkg::*;
#(
   parameter int CNT_W           = 16,
   parameter int RED_TICKS       = 100,
   parameter int RED_AMBER_TICKS = 20,
   parameter int GREEN_TICKS     = 200,
   parameter int AMBER_TICKS     = 30,
   parameter int MIN_GREEN_TICKS = 50,
   parameter int STALL_TICKS     = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_en,
   input  logic             red,
   input  logic             amber,
   input  logic             green,
   input  logic             ped_req,
   output logic             step,
   output logic             ped_ack,
   output logic             fault,
   output logic [CNT_W-1:0] remaining
);

   if (RED_TICKS < 1 || RED_AMBER_TICKS < 1 || GREEN_TICKS < 1 || AMBER_TICKS < 1 ||
       MIN_GREEN_TICKS < 1 || STALL_TICKS < 1 || MIN_GREEN_TICKS > GREEN_TICKS ||
       RED_TICKS >= (1 << CNT_W) || RED_AMBER_TICKS >= (1 << CNT_W) ||
       GREEN_TICKS >= (1 << CNT_W) || AMBER_TICKS >= (1 << CNT_W) ||
       STALL_TICKS >= (1 << CNT_W)) begin : g_param_check
      $error("light_phase_timer: tick parameters out of range");
   end

   // Green may end early once the pre-decrement count is at or below this value.
   localparam logic [CNT_W:0]   PED_LIMIT = (CNT_W+1)'(GREEN_TICKS - MIN_GREEN_TICKS + 1);
   localparam logic [CNT_W-1:0] STALL_VAL = CNT_W'(STALL_TICKS);

   logic [2:0]       light_in, light_q;
   phase_t           in_phase, cur_phase;
   tstate_t          state;
   logic             ped_pending;
   logic             changed, bad, live, accept, ped_early;
   logic             timing_tick, expire, stall_tick, stall_hit, grant;
   logic [CNT_W-1:0] dwell_val, dwell_q, stall_q;
   logic             dwell_one, stall_one;

   assign light_in = {red, amber, green};

   always_comb begin
      in_phase    = decode_light(light_in);
      cur_phase   = decode_light(light_q);
      changed     = (light_in != light_q);
      // light_q decodes as ILLEGAL only straight after reset, so the first phase skips the order check.
      bad         = (in_phase == ILLEGAL) ||
                    (changed && cur_phase != ILLEGAL && next_phase(cur_phase) != in_phase);
      live        = !fault && !bad;
      accept      = live && changed;
      ped_early   = (cur_phase == GREEN) && ped_pending && ({1'b0, dwell_q} <= PED_LIMIT);
      timing_tick = live && !changed && state == TIMING && tick_en && dwell_q != '0;
      expire      = timing_tick && (dwell_one || ped_early);
      stall_tick  = live && !changed && state == WAIT_CHANGE && tick_en && stall_q != '0;
      stall_hit   = stall_tick && stall_one;
      grant       = accept && in_phase == RED && ped_pending;
      dwell_val   = '0;
      case (in_phase)
         RED:       dwell_val = CNT_W'(RED_TICKS);
         RED_AMBER: dwell_val = CNT_W'(RED_AMBER_TICKS);
         GREEN:     dwell_val = CNT_W'(GREEN_TICKS);
         AMBER:     dwell_val = CNT_W'(AMBER_TICKS);
         default:   dwell_val = '0;
      endcase
   end

   phase_counter #(.CNT_W(CNT_W)) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (dwell_val),
      .dec      (timing_tick),
      .clr      (expire),
      .q        (dwell_q),
      .is_one   (dwell_one)
   );

   phase_counter #(.CNT_W(CNT_W)) u_stall (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (expire),
      .load_val (STALL_VAL),
      .dec      (stall_tick),
      .clr      (accept),
      .q        (stall_q),
      .is_one   (stall_one)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         light_q     <= '0;
         state       <= TIMING;
         step        <= 1'b0;
         ped_ack     <= 1'b0;
         fault       <= 1'b0;
         ped_pending <= 1'b0;
      end else begin
         light_q     <= light_in;
         step        <= expire;
         ped_ack     <= grant;
         ped_pending <= grant ? ped_req : (ped_pending | ped_req);
         if (!fault && (bad || stall_hit)) begin
            fault <= 1'b1;
         end
         if (accept) begin
            state <= TIMING;
         end else if (expire) begin
            state <= WAIT_CHANGE;
         end
      end
   end

   assign remaining = dwell_q;

endmodule

// File: tb/tb_light_phase_timer.sv
// Directed bench for light_phase_timer: phase-level vector table plus hand-written corner sequences.
module tb_light_phase_timer;

   localparam logic [2:0] R  = 3'b100;
   localparam logic [2:0] RA = 3'b110;
   localparam logic [2:0] G  = 3'b001;
   localparam logic [2:0] A  = 3'b010;

   logic        clk, rst_n, tick_en, ped_req;
   logic [2:0]  lights;
   logic        step, ped_ack, fault;
   logic [15:0] remaining;

   int n_cmp, n_fail;

   typedef struct {
      logic [2:0] code;
      logic       ped_entry;
      logic       ped_rest;
      int         rem;
      int         dwell;
      int         acks;
   } vec_t;

   vec_t vecs[$];

   light_phase_timer #(
      .CNT_W(16), .RED_TICKS(4), .RED_AMBER_TICKS(2), .GREEN_TICKS(6),
      .AMBER_TICKS(3), .MIN_GREEN_TICKS(2), .STALL_TICKS(5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_en   (tick_en),
      .red       (lights[2]),
      .amber     (lights[1]),
      .green     (lights[0]),
      .ped_req   (ped_req),
      .step      (step),
      .ped_ack   (ped_ack),
      .fault     (fault),
      .remaining (remaining)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] code, input logic pe, input logic pr,
                               input int rem, input int dwell, input int acks);
      vec_t v;
      v.code = code; v.ped_entry = pe; v.ped_rest = pr;
      v.rem = rem; v.dwell = dwell; v.acks = acks;
      return v;
   endfunction

   function automatic void add(input logic [2:0] code, input logic pe, input logic pr,
                               input int rem, input int dwell, input int acks);
      vecs.push_back(mk(code, pe, pr, rem, dwell, acks));
   endfunction

   task automatic do_reset(input logic [2:0] code);
      rst_n   = 1'b0;
      lights  = code;
      ped_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive a phase code, then count edges from its entry edge until step is seen.
   task automatic run_phase(input int idx, input vec_t v);
      int n;
      int acks;
      n    = 0;
      acks = 0;
      lights  = v.code;
      ped_req = v.ped_entry;
      @(posedge clk); #1;
      ped_req = v.ped_rest;
      check($sformatf("v%0d_entry_step", idx), int'(step), 0);
      check($sformatf("v%0d_entry_rem", idx), int'(remaining), v.rem);
      acks += int'(ped_ack);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         acks += int'(ped_ack);
         if (step) begin
            n = i;
            break;
         end
      end
      check($sformatf("v%0d_dwell", idx), n, v.dwell);
      check($sformatf("v%0d_acks", idx), acks, v.acks);
      check($sformatf("v%0d_fault", idx), int'(fault), 0);
   endtask

   initial begin
      int n;
      int steps;
      n_cmp   = 0;
      n_fail  = 0;
      rst_n   = 1'b1;
      tick_en = 1'b1;
      ped_req = 1'b0;
      lights  = R;

      // Three plain cycles.
      repeat (3) begin
         add(R, 0, 0, 4, 4, 0); add(RA, 0, 0, 2, 2, 0);
         add(G, 0, 0, 6, 6, 0); add(A, 0, 0, 3, 3, 0);
      end
      // One-cycle request during red-amber shortens the next green only.
      add(R, 0, 0, 4, 4, 0); add(RA, 1, 0, 2, 2, 0); add(G, 0, 0, 6, 2, 0); add(A, 0, 0, 3, 3, 0);
      add(R, 0, 0, 4, 4, 1); add(RA, 0, 0, 2, 2, 0); add(G, 0, 0, 6, 6, 0); add(A, 0, 0, 3, 3, 0);
      // Request held high, then a request left pending from red.
      add(R, 0, 0, 4, 4, 0);
      repeat (2) begin
         add(RA, 1, 1, 2, 2, 0); add(G, 1, 1, 6, 2, 0);
         add(A, 1, 1, 3, 3, 0); add(R, 1, 1, 4, 4, 1);
      end
      add(RA, 0, 0, 2, 2, 0); add(G, 0, 0, 6, 2, 0); add(A, 0, 0, 3, 3, 0); add(R, 0, 0, 4, 4, 1);
      add(RA, 0, 0, 2, 2, 0); add(G, 0, 0, 6, 6, 0); add(A, 0, 0, 3, 3, 0);

      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_step", int'(step), 0);
      check("rst_ack", int'(ped_ack), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_rem", int'(remaining), 0);
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) run_phase(i, vecs[i]);

      // Sequencer never answers the green step.
      do_reset(G);
      run_phase(100, mk(G, 0, 0, 6, 6, 0));
      n = 0;
      steps = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         steps += int'(step);
         if (fault) begin
            n = i;
            break;
         end
      end
      check("stall_ticks", n, 5);
      check("stall_no_step", steps, 0);
      lights = A;
      steps  = 0;
      repeat (10) begin
         @(posedge clk); #1;
         steps += int'(step) + int'(ped_ack);
      end
      check("fault_sticky", int'(fault), 1);
      check("fault_no_pulse", steps, 0);
      check("fault_rem", int'(remaining), 0);

      // Green straight to red.
      do_reset(G);
      @(posedge clk); #1;
      check("skip_pre_fault", int'(fault), 0);
      check("skip_pre_rem", int'(remaining), 6);
      repeat (2) @(posedge clk);
      #1;
      lights = R;
      @(posedge clk); #1;
      check("skip_fault", int'(fault), 1);
      check("skip_rem_hold", int'(remaining), 4);

      // Illegal code mid-red.
      do_reset(R);
      @(posedge clk); #1;
      check("illegal_pre_fault", int'(fault), 0);
      lights = 3'b011;
      @(posedge clk); #1;
      check("illegal_fault", int'(fault), 1);
      check("illegal_step", int'(step), 0);

      // Asynchronous reset mid-green.
      do_reset(G);
      @(posedge clk); #1;
      check("mid_entry_rem", int'(remaining), 6);
      repeat (3) @(posedge clk);
      #1;
      check("mid_rem", int'(remaining), 3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rem", int'(remaining), 0);
      check("async_fault", int'(fault), 0);
      check("async_step", int'(step), 0);
      check("async_ack", int'(ped_ack), 0);
      lights = R;
      @(negedge clk) rst_n = 1'b1;
      run_phase(101, mk(R, 0, 0, 4, 4, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
